// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: memory read port (req/ack) and decode port (valid/ready).
// master = fetch unit, slave = memory plus decode side.
interface instr_fetch_unit_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [63:0]   instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the word addressed by pc from instruction memory,
// hands it to decode, pulses pc_advance per delivered word; supports flush and bus timeout.
module instr_fetch_unit #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 16,
  parameter int unsigned ADDR_LSB = 12,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [63:0]         pc,
  input  logic                enable,
  input  logic                flush,
  instr_fetch_unit_if.master  bus,
  output logic                pc_advance,
  output logic                fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [63:0]   instr_pc_q, instr_pc_d;
  logic          instr_valid_q, instr_valid_d;
  logic          pc_advance_q, pc_advance_d;
  logic          fetch_err_q, fetch_err_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          launch;
  logic          tmo_hit;

  // Timeout fires on the wait cycle that would bring the counter to TIMEOUT.
  assign tmo_hit = (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pc_advance_d  = 1'b0;
    fetch_err_d   = fetch_err_q;
    cnt_d         = cnt_q;
    launch        = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          instr_valid_d = 1'b0;
        end else if (enable && !fetch_err_q) begin
          launch = 1'b1;
        end
      end

      REQ: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (flush) begin
            state_d = IDLE;
          end else begin
            instr_d       = bus.mem_rdata;
            instr_valid_d = 1'b1;
            pc_advance_d  = 1'b1;
            state_d       = HOLD;
          end
        end else if (tmo_hit) begin
          fetch_err_d   = 1'b1;
          mem_req_d     = 1'b0;
          instr_valid_d = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush) begin
            state_d = DROP;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          instr_valid_d = 1'b0;
          state_d       = IDLE;
        end else if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = IDLE;
          launch        = enable && !fetch_err_q;
        end
      end

      DROP: begin
        // Request cannot be withdrawn; wait out the ack and throw the data away.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (tmo_hit) begin
          fetch_err_d   = 1'b1;
          mem_req_d     = 1'b0;
          instr_valid_d = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d    = REQ;
      mem_req_d  = 1'b1;
      mem_addr_d = pc[ADDR_LSB +: AW];
      instr_pc_d = pc;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      pc_advance_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      pc_advance_q  <= pc_advance_d;
      fetch_err_q   <= fetch_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign pc_advance      = pc_advance_q;
  assign fetch_err       = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-flag reference model.
module tb_instr_fetch_unit;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 16;
  localparam int unsigned LSB = 12;
  localparam int unsigned TMO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pc;
  logic        enable;
  logic        flush;
  logic        pc_advance;
  logic        fetch_err;

  instr_fetch_unit_if #(.DW(DW), .AW(AW)) bus ();

  instr_fetch_unit #(.DW(DW), .AW(AW), .ADDR_LSB(LSB), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .enable     (enable),
    .flush      (flush),
    .bus        (bus.master),
    .pc_advance (pc_advance),
    .fetch_err  (fetch_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one outstanding request, a discard flag, a wait count,
  // and the word currently offered to decode.
  bit          m_req, m_drop, m_valid, m_adv, m_err;
  logic [15:0] m_addr;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  int unsigned m_wait;

  task automatic model_reset();
    m_req = 0; m_drop = 0; m_valid = 0; m_adv = 0; m_err = 0;
    m_addr = '0; m_instr = '0; m_ipc = '0; m_wait = 0;
  endtask

  task automatic model_step();
    bit go;
    go = 0;
    m_adv = 0;
    if (m_req) begin
      if (bus.mem_ack) begin
        m_req = 0;
        if (!m_drop && !flush) begin
          m_valid = 1; m_instr = bus.mem_rdata; m_adv = 1;
        end
        m_drop = 0;
      end else if (m_wait + 1 == TMO) begin
        m_err = 1; m_req = 0; m_drop = 0; m_valid = 0;
      end else begin
        m_wait++;
        if (flush) m_drop = 1;
      end
    end else if (flush) begin
      m_valid = 0;
    end else if (m_valid) begin
      if (bus.instr_ready) begin
        m_valid = 0;
        go = enable && !m_err;
      end
    end else begin
      go = enable && !m_err;
    end
    if (go) begin
      m_req = 1; m_addr = pc[LSB +: AW]; m_ipc = pc; m_wait = 0;
    end
  endtask

  task automatic check_outputs();
    expect_eq("mem_req",     bus.mem_req,     m_req);
    expect_eq("mem_addr",    bus.mem_addr,    m_addr);
    expect_eq("instr_valid", bus.instr_valid, m_valid);
    expect_eq("instr",       bus.instr,       m_instr);
    expect_eq("instr_pc",    bus.instr_pc,    m_ipc);
    expect_eq("pc_advance",  pc_advance,      m_adv);
    expect_eq("fetch_err",   fetch_err,       m_err);
  endtask

  // Stimulus knobs (percentages / ranges) and memory responder state.
  int unsigned k_en, k_fl, k_rdy, k_spur, k_dmin, k_dmax;
  bit          k_noack, k_step, k_randpc, k_fixdata;
  logic [31:0] k_data;
  bit          armed;
  int unsigned dly;
  int unsigned adv_cnt, req_cyc;
  logic [15:0] launch_q[$];
  bit          prev_req;

  task automatic apply_stim();
    enable          = ($urandom_range(99) < k_en);
    flush           = ($urandom_range(99) < k_fl);
    bus.instr_ready = ($urandom_range(99) < k_rdy);
    if (k_step) begin
      if (m_adv) pc = pc + 64'h1000;
    end else if (k_randpc) begin
      pc = {$urandom, $urandom};
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    if (m_req) begin
      if (!k_noack) begin
        if (!armed) begin
          armed = 1;
          dly   = $urandom_range(k_dmax, k_dmin);
        end
        if (dly == 0) begin
          bus.mem_ack = 1'b1;
          armed       = 0;
          if (k_fixdata) bus.mem_rdata = k_data;
        end else begin
          dly--;
        end
      end
    end else begin
      armed = 0;
      if ($urandom_range(99) < k_spur) bus.mem_ack = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset) model_step();
    @(negedge clock);
    check_outputs();
    if (pc_advance) adv_cnt++;
    if (bus.mem_req) req_cyc++;
    if (bus.mem_req && !prev_req) launch_q.push_back(bus.mem_addr);
    prev_req = bus.mem_req;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      apply_stim();
      cycle();
    end
  endtask

  task automatic quiet_knobs();
    k_en = 0; k_fl = 0; k_rdy = 0; k_spur = 0; k_dmin = 0; k_dmax = 0;
    k_noack = 0; k_step = 0; k_randpc = 0; k_fixdata = 0; k_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0; flush = 1'b0; bus.mem_ack = 1'b0; bus.instr_ready = 1'b0;
    model_reset();
    armed = 0; prev_req = 0;
    repeat (2) cycle();
    reset = 1'b1;
    adv_cnt = 0; req_cyc = 0;
    launch_q.delete();
  endtask

  initial begin
    pc = '0; enable = 0; flush = 0;
    bus.mem_ack = 0; bus.mem_rdata = '0; bus.instr_ready = 0;
    quiet_knobs();
    model_reset();
    armed = 0; dly = 0; prev_req = 0; adv_cnt = 0; req_cyc = 0;
    @(negedge clock);
    do_reset();

    // Basic fetch with backpressure.
    pc = 64'h3000; k_fixdata = 1; k_data = 32'hDEADBEEF; k_dmin = 1; k_dmax = 1;
    k_en = 100; run(1);
    k_en = 0; run(10);
    expect_eq("basic_addr",  bus.mem_addr,    64'h3);
    expect_eq("basic_instr", bus.instr,       64'hDEADBEEF);
    expect_eq("basic_pc",    bus.instr_pc,    64'h3000);
    expect_eq("basic_valid", bus.instr_valid, 64'h1);
    expect_eq("basic_adv",   adv_cnt,         64'h1);
    k_rdy = 100; run(2);
    expect_eq("basic_drain", bus.instr_valid, 64'h0);

    // Back-to-back with PC stepping.
    quiet_knobs(); do_reset();
    pc = 64'hFFF; k_step = 1; k_en = 100; k_rdy = 100; k_dmin = 0; k_dmax = 2;
    run(30);
    for (int i = 0; i < 4; i++) begin
      if (launch_q.size() > i) expect_eq("b2b_addr", launch_q[i], 64'(i));
      else expect_eq("b2b_count", launch_q.size(), 64'd4);
    end

    // Flush while in flight, then a normal fetch.
    quiet_knobs(); do_reset();
    pc = 64'h0000_0000_0012_3000; k_fixdata = 1; k_data = 32'h12345678; k_dmin = 3; k_dmax = 3;
    k_en = 100; run(1);
    k_en = 0; k_fl = 100; run(1);
    k_fl = 0; run(8);
    expect_eq("flush_valid", bus.instr_valid, 64'h0);
    expect_eq("flush_adv",   adv_cnt,         64'h0);
    k_en = 100; run(1);
    k_en = 0; run(8);
    expect_eq("flush_next_instr", bus.instr, 64'h12345678);
    expect_eq("flush_next_adv",   adv_cnt,   64'h1);

    // Timeout, then enable ignored while error is sticky.
    quiet_knobs(); do_reset();
    pc = 64'h5000; k_noack = 1; k_en = 100;
    run(300);
    expect_eq("tmo_err",    fetch_err,   64'h1);
    expect_eq("tmo_req",    bus.mem_req, 64'h0);
    expect_eq("tmo_cycles", req_cyc,     64'd255);
    expect_eq("tmo_adv",    adv_cnt,     64'h0);

    // Ack on the last permitted wait cycle completes normally.
    quiet_knobs(); do_reset();
    pc = 64'h7000; k_dmin = 254; k_dmax = 254;
    k_en = 100; run(1);
    k_en = 0; run(260);
    expect_eq("tmo_edge_err",   fetch_err,       64'h0);
    expect_eq("tmo_edge_valid", bus.instr_valid, 64'h1);
    expect_eq("tmo_edge_adv",   adv_cnt,         64'h1);

    // Asynchronous reset while a request is outstanding.
    quiet_knobs(); do_reset();
    pc = 64'h9000; k_dmin = 10; k_dmax = 10; k_en = 100;
    run(3);
    expect_eq("arst_pre_req", bus.mem_req, 64'h1);
    reset = 1'b0;
    #1;
    expect_eq("arst_req",   bus.mem_req,     64'h0);
    expect_eq("arst_addr",  bus.mem_addr,    64'h0);
    expect_eq("arst_valid", bus.instr_valid, 64'h0);
    expect_eq("arst_ipc",   bus.instr_pc,    64'h0);
    @(negedge clock);
    do_reset();
    k_dmin = 0; k_dmax = 3; k_en = 100; k_rdy = 100;
    run(20);

    // Randomized mix.
    quiet_knobs(); do_reset();
    k_randpc = 1; k_en = 70; k_fl = 10; k_rdy = 60; k_spur = 10; k_dmin = 0; k_dmax = 6;
    run(3000);
    k_randpc = 0; k_step = 1; k_en = 90; k_fl = 5; k_rdy = 80; k_dmax = 20;
    run(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
